// File: rtl/spi_ms_pkg.sv
`default_nettype none
// spi_ms_pkg: shared state encoding, SPI mode constants and counter-width helper.
package spi_ms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_GAP,
    WAIT_NEXT
  } spi_ms_state_e;

  localparam int SPI_CPOL = 0;
  localparam int SPI_CPHA = 0;

  // Bits needed for a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ms_clk_gen.sv
`default_nettype none
// spi_ms_clk_gen: half-bit counter producing SPI_Clk and edge strobes while enabled.
module spi_ms_clk_gen
  import spi_ms_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic spi_clk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CW = cnt_w(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_HALF_BIT - 1);

  logic [CW-1:0] cnt;
  logic          half_end;

  // Strobes flag the cycle whose closing edge toggles SPI_Clk.
  assign half_end = en && (cnt == CNT_LAST);
  assign rise_stb = half_end && !spi_clk;
  assign fall_stb = half_end && spi_clk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt     <= '0;
      spi_clk <= 1'(SPI_CPOL);
    end else if (half_end) begin
      cnt     <= '0;
      spi_clk <= !spi_clk;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_ms_controller.sv
`default_nettype none
// spi_ms_controller: SPI mode-0 master sequencer framing each word with chip select.
// Define SPI_MS_BURST_EN to add TX_Last and keep CS_n low across words of a burst.
module spi_ms_controller
  import spi_ms_pkg::*;
#(
  parameter int DATA_W            = 8,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] TX_Data,
  input  logic              TX_DV,
`ifdef SPI_MS_BURST_EN
  input  logic              TX_Last,
`endif
  output logic              TX_Ready,
  output logic [DATA_W-1:0] RX_Data,
  output logic              RX_DV,
  output logic              SPI_Clk,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              SPI_CS_n
);
  localparam int TMR_MAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ?
                           CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
  localparam int KW = cnt_w(2 * DATA_W);
  localparam int TW = cnt_w(TMR_MAX);
  localparam logic [KW-1:0] K_LAST    = KW'(2 * DATA_W - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(CS_INACTIVE_CLKS - 1);

  spi_ms_state_e     state, state_nx;
  logic [TW-1:0]     tmr;
  logic [KW-1:0]     half_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              accept;
  logic              shift_en;
  logic              rise_stb, fall_stb;
  logic              sample_stb, launch_stb;
  logic              shift_done;
  logic              last_word;

  assign accept     = TX_DV && TX_Ready;
  assign shift_en   = (state == SHIFT);
  assign sample_stb = (SPI_CPHA == 0) ? rise_stb : fall_stb;
  assign launch_stb = (SPI_CPHA == 0) ? fall_stb : rise_stb;
  assign shift_done = fall_stb && (half_cnt == K_LAST);
  assign SPI_MOSI   = tx_sr[DATA_W-1];

  spi_ms_clk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_clk_gen (
    .clk     (Clk),
    .rst     (Rst),
    .en      (shift_en),
    .spi_clk (SPI_Clk),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

`ifdef SPI_MS_BURST_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_word <= 1'b1;
    end else if (accept) begin
      last_word <= TX_Last;
    end
  end
`else
  assign last_word = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    TX_Ready = 1'b0;
    SPI_CS_n = 1'b0;
    case (state)
      IDLE: begin
        TX_Ready = 1'b1;
        SPI_CS_n = 1'b1;
        if (accept) state_nx = CS_SETUP;
      end
      CS_SETUP: begin
        if (tmr == HALF_LAST) state_nx = SHIFT;
      end
      SHIFT: begin
        if (shift_done) state_nx = CS_HOLD;
      end
      CS_HOLD: begin
        if (tmr == HALF_LAST) state_nx = last_word ? CS_GAP : WAIT_NEXT;
      end
      CS_GAP: begin
        SPI_CS_n = 1'b1;
        if (tmr == GAP_LAST) state_nx = IDLE;
      end
      WAIT_NEXT: begin
        TX_Ready = 1'b1;
        if (accept) state_nx = CS_SETUP;
      end
      default: begin
        SPI_CS_n = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Timer restarts on every state change; half_cnt indexes the SHIFT half-periods.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmr      <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      RX_Data  <= '0;
      RX_DV    <= 1'b0;
    end else begin
      RX_DV <= 1'b0;
      tmr   <= (state_nx != state) ? '0 : tmr + 1'b1;
      if (!shift_en) begin
        half_cnt <= '0;
      end else if (rise_stb || fall_stb) begin
        half_cnt <= half_cnt + 1'b1;
      end
      if (accept) begin
        tx_sr <= TX_Data;
      end else if (launch_stb && !shift_done) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
      if (sample_stb) begin
        rx_sr <= {rx_sr[DATA_W-2:0], SPI_MISO};
      end
      if (shift_done) begin
        RX_DV   <= 1'b1;
        RX_Data <= rx_sr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_ms_controller.sv
`default_nettype none
`timescale 1ns/1ps
// tb_spi_ms_controller: vector table, slave model and scoreboard for spi_ms_controller.
module tb_spi_ms_controller;
  localparam int W     = 8;
  localparam int H     = 2;
  localparam int G     = 1;
  localparam int T_RX  = H + 2 * W * H + 1;  // 35
  localparam int T_CSR = T_RX + H;           // 37
  localparam int T_RDY = T_CSR + G;          // 38

  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] TX_Data;
  logic         TX_DV;
  logic         TX_Last;
  logic         TX_Ready, RX_DV, SPI_Clk, SPI_MOSI, SPI_MISO, SPI_CS_n;
  logic [W-1:0] RX_Data;

  logic [15:0]  tx1, rx1;
  logic         dv1, rdy1, rxdv1, sclk1, mosi1, cs1;

  always #5 Clk = ~Clk;

  spi_ms_controller #(.DATA_W(W), .CLKS_PER_HALF_BIT(H), .CS_INACTIVE_CLKS(G)) dut (
    .Clk(Clk), .Rst(Rst), .TX_Data(TX_Data), .TX_DV(TX_DV),
`ifdef SPI_MS_BURST_EN
    .TX_Last(TX_Last),
`endif
    .TX_Ready(TX_Ready), .RX_Data(RX_Data), .RX_DV(RX_DV), .SPI_Clk(SPI_Clk),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_CS_n(SPI_CS_n)
  );

  // Wide, fast instance with MISO looped back to MOSI.
  spi_ms_controller #(.DATA_W(16), .CLKS_PER_HALF_BIT(1), .CS_INACTIVE_CLKS(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .TX_Data(tx1), .TX_DV(dv1),
`ifdef SPI_MS_BURST_EN
    .TX_Last(1'b1),
`endif
    .TX_Ready(rdy1), .RX_Data(rx1), .RX_DV(rxdv1), .SPI_Clk(sclk1),
    .SPI_MOSI(mosi1), .SPI_MISO(mosi1), .SPI_CS_n(cs1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Slave model: loads a word on CS_n fall or after each completed word, shifts on SPI_Clk fall.
  logic [W-1:0] slave_next = '0;
  logic [W-1:0] s_tx = '0, s_rx = '0, s_got = '0;
  int           s_bits = 0, r_bits = 0;
  logic         cs_p = 1'b1, clk_p = 1'b0;

  assign SPI_MISO = s_tx[W-1];

  always @(SPI_CS_n or SPI_Clk) begin
    if (SPI_CS_n !== 1'b0) begin
      cs_p  = 1'b1;
      clk_p = (SPI_Clk === 1'b1);
    end else if (cs_p) begin
      cs_p   = 1'b0;
      clk_p  = (SPI_Clk === 1'b1);
      s_tx   = slave_next;
      s_bits = 0;
      r_bits = 0;
    end else if (SPI_Clk === 1'b1 && !clk_p) begin
      clk_p = 1'b1;
      s_rx  = {s_rx[W-2:0], SPI_MOSI};
      r_bits++;
      if (r_bits == W) begin
        s_got  = s_rx;
        r_bits = 0;
      end
    end else if (SPI_Clk === 1'b0 && clk_p) begin
      clk_p = 1'b0;
      s_bits++;
      if (s_bits == W) begin
        s_tx   = slave_next;
        s_bits = 0;
      end else begin
        s_tx = {s_tx[W-2:0], 1'b0};
      end
    end
  end

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] mosi;
    int           rel;
  } exp_t;
  exp_t sbq[$];

  // Bus monitor: frame timing relative to the accept cycle, plus the RX scoreboard.
  int   acc_cyc = 0, acc_count = 0, rises = 0, rx_count = 0, cs_rises = 0;
  int   cs_fall_rel = -1, cs_rise_rel = -1, high_run = 0, last_gap = 0, rx_at_csrise = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, ready_bad = 1'b0;

  always @(negedge Clk) begin
    int   rel;
    exp_t e;
    if (TX_DV === 1'b1 && TX_Ready === 1'b1) begin
      acc_cyc = cyc;
      acc_count++;
      rises     = 0;
      ready_bad = 1'b0;
    end
    rel = cyc - acc_cyc;
    if (!prev_sclk && SPI_Clk === 1'b1) rises++;
    if (prev_cs && SPI_CS_n === 1'b0) begin
      cs_fall_rel = rel;
      last_gap    = high_run;
    end
    if (!prev_cs && SPI_CS_n === 1'b1) begin
      cs_rise_rel  = rel;
      cs_rises++;
      rx_at_csrise = rx_count;
    end
    high_run = (SPI_CS_n === 1'b1) ? high_run + 1 : 0;
    if (acc_count > 0 && rel >= 1 && rel < T_CSR && TX_Ready === 1'b1) ready_bad = 1'b1;
    if (RX_DV === 1'b1) begin
      rx_count++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got RX_DV=1 data %0h required no RX_DV", RX_Data);
      end else begin
        e = sbq.pop_front();
        check("rx_data", 32'(RX_Data), 32'(e.rx));
        check("slave_mosi", 32'(s_got), 32'(e.mosi));
        check("rx_dv_cycle", 32'(rel), 32'(e.rel));
      end
    end
    prev_cs   = (SPI_CS_n !== 1'b0);
    prev_sclk = (SPI_Clk === 1'b1);
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] sw, input logic last,
                      input bit hold);
    int n;
    bit ok;
    @(posedge Clk); #1;
    TX_Data    = d;
    TX_DV      = 1'b1;
    TX_Last    = last;
    slave_next = sw;
    n  = 0;
    ok = 0;
    while (!ok && n < 200) begin
      @(negedge Clk); #1;
      if (TX_Ready === 1'b1) ok = 1;
      n++;
    end
    if (ok) sbq.push_back('{rx: sw, mosi: d, rel: T_RX});
    else check("accept_timeout", 32'd0, 32'd1);
    @(posedge Clk); #1;
    if (!hold) TX_DV = 1'b0;
  endtask

  task automatic wait_ready(output int rel);
    int n;
    n   = 0;
    rel = -1;
    while (n < 200) begin
      @(negedge Clk); #1;
      if (TX_Ready === 1'b1) begin
        rel = cyc - acc_cyc;
        break;
      end
      n++;
    end
    if (rel < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rel(input int target);
    int n;
    n = 0;
    while (n < 200 && (cyc - acc_cyc) != target) begin
      @(negedge Clk); #1;
      n++;
    end
    if ((cyc - acc_cyc) != target) check("wait_rel_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] slave;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   rrel, a_prev, a_cnt, rxc, csr, r, bad, r1rise, r1rel;
    logic [15:0] r1data;
    logic p1;

    vecs[0] = '{tx: 8'hA5, slave: 8'h3C};
    vecs[1] = '{tx: 8'h00, slave: 8'hFF};
    vecs[2] = '{tx: 8'hFF, slave: 8'h00};
    vecs[3] = '{tx: 8'h81, slave: 8'h7E};
    vecs[4] = '{tx: 8'h5A, slave: 8'hC3};

    Rst = 1'b1; TX_DV = 1'b0; TX_Data = '0; TX_Last = 1'b1;
    dv1 = 1'b0; tx1 = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_tx_ready", 32'(TX_Ready), 32'd1);
    check("rst_rx_dv", 32'(RX_DV), 32'd0);
    check("rst_rx_data", 32'(RX_Data), 32'd0);
    check("rst_spi_clk", 32'(SPI_Clk), 32'd0);
    check("rst_mosi", 32'(SPI_MOSI), 32'd0);
    check("rst_cs_n", 32'(SPI_CS_n), 32'd1);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Single framed words from the vector table.
    for (int i = 0; i < 5; i++) begin
      rxc = rx_count;
      send(vecs[i].tx, vecs[i].slave, 1'b1, 1'b0);
      wait_ready(rrel);
      check("sclk_rises", 32'(rises), 32'(W));
      check("cs_fall_cycle", 32'(cs_fall_rel), 32'd1);
      check("cs_rise_cycle", 32'(cs_rise_rel), 32'(T_CSR));
      check("ready_cycle", 32'(rrel), 32'(T_RDY));
      check("rx_dv_count", 32'(rx_count), 32'(rxc + 1));
    end

    // Back-to-back with TX_DV held high.
    send(8'h00, 8'h5A, 1'b1, 1'b1);
    a_prev = acc_cyc;
    send(8'hFF, 8'h96, 1'b1, 1'b0);
    check("b2b_accept_cycle", 32'(acc_cyc - a_prev), 32'(T_RDY));
    wait_ready(rrel);
    // CS_n is high for the G-cycle gap plus the IDLE cycle that accepts the next word.
    check("b2b_cs_high_len", 32'(last_gap), 32'(G + 1));

    // TX_DV pulsed mid-transfer is ignored.
    a_cnt = acc_count;
    rxc   = rx_count;
    send(8'hC3, 8'h24, 1'b1, 1'b0);
    wait_rel(9);
    @(posedge Clk); #1;
    TX_DV = 1'b1; TX_Data = 8'hEE;
    @(posedge Clk); #1;
    TX_DV = 1'b0;
    wait_ready(rrel);
    check("ignore_ready_cycle", 32'(rrel), 32'(T_RDY));
    check("ignore_ready_low", 32'(ready_bad), 32'd0);
    repeat (50) @(posedge Clk);
    check("ignore_accepts", 32'(acc_count), 32'(a_cnt + 1));
    check("ignore_frames", 32'(rx_count), 32'(rxc + 1));

    // Reset during cycle 20 aborts the frame.
    send(8'h77, 8'h11, 1'b1, 1'b0);
    wait_rel(19);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    sbq.delete();
    rxc = rx_count;
    @(negedge Clk); #1;
    check("abort_cs_n", 32'(SPI_CS_n), 32'd1);
    check("abort_spi_clk", 32'(SPI_Clk), 32'd0);
    check("abort_tx_ready", 32'(TX_Ready), 32'd1);
    repeat (60) @(posedge Clk);
    check("abort_no_rx_dv", 32'(rx_count), 32'(rxc));

    // 16-bit, one clock per half-bit, loopback.
    @(posedge Clk); #1;
    tx1 = 16'h8001; dv1 = 1'b1;
    a_prev = -1;
    for (int n = 0; n < 50 && a_prev < 0; n++) begin
      @(negedge Clk); #1;
      if (rdy1 === 1'b1) a_prev = cyc;
    end
    if (a_prev < 0) check("w16_accept_timeout", 32'd0, 32'd1);
    @(posedge Clk); #1;
    dv1 = 1'b0;
    bad = 0; r1rise = 0; r1rel = -1; r1data = '0; p1 = 1'b0;
    for (int n = 0; n < 45; n++) begin
      @(negedge Clk); #1;
      r = cyc - a_prev;
      if (r >= 2 && r <= 33 && sclk1 !== 1'((r - 2) & 1)) bad++;
      if (!p1 && sclk1 === 1'b1) r1rise++;
      p1 = (sclk1 === 1'b1);
      if (rxdv1 === 1'b1) begin
        r1rel  = r;
        r1data = rx1;
      end
    end
    check("w16_rx_data", 32'(r1data), 32'h8001);
    check("w16_rx_dv_cycle", 32'(r1rel), 32'd34);
    check("w16_sclk_toggle", 32'(bad), 32'd0);
    check("w16_sclk_rises", 32'(r1rise), 32'd16);

`ifdef SPI_MS_BURST_EN
    // Three-word burst with CS_n held low until the TX_Last word.
    csr = cs_rises;
    rxc = rx_count;
    send(8'h11, 8'hA1, 1'b0, 1'b0);
    send(8'h22, 8'hB2, 1'b0, 1'b0);
    send(8'h33, 8'hC3, 1'b1, 1'b0);
    wait_ready(rrel);
    check("burst_cs_rises", 32'(cs_rises), 32'(csr + 1));
    check("burst_rx_count", 32'(rx_count), 32'(rxc + 3));
    check("burst_cs_after_last", 32'(rx_at_csrise), 32'(rxc + 3));
`else
    csr = 0;
`endif

    repeat (5) @(posedge Clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
